mux_share_arbiter: RTL and testbench



---
 rtl/mux_share_arbiter_pkg.sv | 16 +
 rtl/mux_arb_defs.vh | 9 +
 rtl/mux_arb_fsm.sv | 73 +++++++
 rtl/mux_share_arbiter.sv | 79 +++++++
 tb/tb_mux_share_arbiter.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/mux_share_arbiter_pkg.sv
// Types and helpers shared by the mux-share arbiter top and its grant FSM.
package mux_share_arbiter_pkg;
`include "mux_arb_defs.vh"

    typedef enum logic [1:0] {
        ST_IDLE = `MUX_ARB_ST_IDLE,
        ST_GNT0 = `MUX_ARB_ST_GNT0,
        ST_GNT1 = `MUX_ARB_ST_GNT1
    } arb_state_e;

    localparam int STAT_W = `MUX_ARB_STAT_W;

    function automatic int hold_w(input int max_hold);
        return $clog2(max_hold) + 1;
    endfunction
endpackage

// File: rtl/mux_arb_defs.vh
// Shared encodings for the mux-share arbiter: FSM state codes and stats counter width.
// Included by the RTL package and by the testbench.
`ifndef MUX_ARB_DEFS_VH
`define MUX_ARB_DEFS_VH
`define MUX_ARB_ST_IDLE 2'd0
`define MUX_ARB_ST_GNT0 2'd1
`define MUX_ARB_ST_GNT1 2'd2
`define MUX_ARB_STAT_W  16
`endif

// File: rtl/mux_arb_fsm.sv
// Round-robin grant FSM for two requesters with a bounded hold under contention.
// Owns state, last_gnt and hold_cnt; grants are plain state decodes.
module mux_arb_fsm
    import mux_share_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1
);
    localparam int HW = hold_w(MAX_HOLD);
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

    arb_state_e    state_q, state_d;
    logic          last_q, last_d;
    logic [HW-1:0] hold_q, hold_d;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        hold_d  = hold_q;
        if (!en) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req0 && req1)  state_d = last_q ? ST_GNT0 : ST_GNT1;
                    else if (req0)     state_d = ST_GNT0;
                    else if (req1)     state_d = ST_GNT1;
                end
                ST_GNT0: begin
                    if (!req0)                            state_d = req1 ? ST_GNT1 : ST_IDLE;
                    else if (req1 && hold_q == HOLD_LAST) state_d = ST_GNT1;
                end
                ST_GNT1: begin
                    if (!req1)                            state_d = req0 ? ST_GNT0 : ST_IDLE;
                    else if (req0 && hold_q == HOLD_LAST) state_d = ST_GNT0;
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // hold_cnt only advances while the owner keeps the mux and the other side waits
        if (state_d != state_q) begin
            hold_d = '0;
            if (state_d == ST_GNT0)      last_d = 1'b0;
            else if (state_d == ST_GNT1) last_d = 1'b1;
        end else if ((state_q == ST_GNT0 && req1) || (state_q == ST_GNT1 && req0)) begin
            hold_d = hold_q + HW'(1);
        end
        if (!en) hold_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            last_q  <= 1'b1;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
        end
    end

    assign gnt0 = (state_q == ST_GNT0);
    assign gnt1 = (state_q == ST_GNT1);
endmodule

// File: rtl/mux_share_arbiter.sv
// Two-requester arbiter sharing one enabled 2:1 mux; registers the mux result downstream.
// Optional per-requester grant-cycle counters under MUX_ARB_STATS_EN.
module mux_share_arbiter
    import mux_share_arbiter_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              req0,
    input  logic              req1,
    input  logic [DATA_W-1:0] in0,
    input  logic [DATA_W-1:0] in1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              mux_sel,
    output logic              mux_en,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid
`ifdef MUX_ARB_STATS_EN
    ,
    output logic [STAT_W-1:0] gnt_cnt0,
    output logic [STAT_W-1:0] gnt_cnt1
`endif
);
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_valid_q;

    mux_arb_fsm #(.MAX_HOLD(MAX_HOLD)) u_fsm (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .req0 (req0),
        .req1 (req1),
        .gnt0 (gnt0),
        .gnt1 (gnt1)
    );

    assign mux_en  = gnt0 | gnt1;
    assign mux_sel = gnt1;

    always_comb begin
        out_data_d = '0;
        if (mux_en) out_data_d = mux_sel ? in1 : in0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_data_q  <= out_data_d;
            out_valid_q <= mux_en;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;

`ifdef MUX_ARB_STATS_EN
    logic [STAT_W-1:0] cnt0_q, cnt1_q;

    // Saturating grant-cycle counters; en does not gate them, only the grants do
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            if (gnt0 && cnt0_q != '1) cnt0_q <= cnt0_q + STAT_W'(1);
            if (gnt1 && cnt1_q != '1) cnt1_q <= cnt1_q + STAT_W'(1);
        end
    end

    assign gnt_cnt0 = cnt0_q;
    assign gnt_cnt1 = cnt1_q;
`endif
endmodule

// File: tb/tb_mux_share_arbiter.sv
// Directed bench for mux_share_arbiter: grant checks per cycle, data via a scoreboard queue.
// Stats counters are exercised when MUX_ARB_STATS_EN is defined.
`include "mux_arb_defs.vh"
module tb_mux_share_arbiter;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst, en, req0, req1;
    logic [DW-1:0] in0, in1;
    logic          gnt0, gnt1, mux_sel, mux_en, out_valid;
    logic [DW-1:0] out_data;
    logic          d1_gnt0, d1_gnt1, d1_mux_sel, d1_mux_en, d1_out_valid;
    logic [DW-1:0] d1_out_data;
`ifdef MUX_ARB_STATS_EN
    logic [`MUX_ARB_STAT_W-1:0] gnt_cnt0, gnt_cnt1, d1_gnt_cnt0, d1_gnt_cnt1;
`endif

    int tests = 0;
    int fails = 0;
    logic [DW-1:0] exp_q[$];
    logic cur0 = 1'b0, cur1 = 1'b0;

    always #5 clk = ~clk;

    mux_share_arbiter #(.DATA_W(DW), .MAX_HOLD(4)) u_dut (
        .clk(clk), .rst(rst), .en(en), .req0(req0), .req1(req1), .in0(in0), .in1(in1),
        .gnt0(gnt0), .gnt1(gnt1), .mux_sel(mux_sel), .mux_en(mux_en),
        .out_data(out_data), .out_valid(out_valid)
`ifdef MUX_ARB_STATS_EN
        , .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
`endif
    );

    mux_share_arbiter #(.DATA_W(DW), .MAX_HOLD(1)) u_dut1 (
        .clk(clk), .rst(rst), .en(en), .req0(req0), .req1(req1), .in0(in0), .in1(in1),
        .gnt0(d1_gnt0), .gnt1(d1_gnt1), .mux_sel(d1_mux_sel), .mux_en(d1_mux_en),
        .out_data(d1_out_data), .out_valid(d1_out_valid)
`ifdef MUX_ARB_STATS_EN
        , .gnt_cnt0(d1_gnt_cnt0), .gnt_cnt1(d1_gnt_cnt1)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: every valid output must match the oldest expected data word
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL sb_unexpected: got valid data 0x%0h expected no output @%0t", out_data, $time);
            end else begin
                chk("sb_out_data", 32'(out_data), 32'(exp_q.pop_front()));
            end
        end
    end

    // One clock: apply inputs, predict the registered data from the current grant, check next grant
    task automatic cyc(input logic r, input logic e, input logic q0, input logic q1,
                       input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                       input logic x0, input logic x1, input string nm);
        rst = r; en = e; req0 = q0; req1 = q1; in0 = d0; in1 = d1;
        if (!r) begin
            if (cur0)      exp_q.push_back(d0);
            else if (cur1) exp_q.push_back(d1);
        end
        @(posedge clk);
        #1;
        chk({nm, "_gnt0"},    32'(gnt0),    32'(x0));
        chk({nm, "_gnt1"},    32'(gnt1),    32'(x1));
        chk({nm, "_mux_sel"}, 32'(mux_sel), 32'(x1));
        chk({nm, "_mux_en"},  32'(mux_en),  32'(x0 | x1));
        cur0 = r ? 1'b0 : x0;
        cur1 = r ? 1'b0 : x1;
    endtask

    initial begin
        // Reset with all requests high
        cyc(1, 1, 1, 1, 8'h11, 8'h22, 0, 0, "rst_a");
        cyc(1, 1, 1, 1, 8'h11, 8'h22, 0, 0, "rst_b");
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data",  32'(out_data),  0);

        // Sustained contention: MAX_HOLD=4 gives 4/4 blocks, MAX_HOLD=1 alternates
        for (int i = 0; i < 10; i++) begin
            logic x0;
            logic [DW-1:0] a, b;
            x0 = (i < 4) || (i >= 8);
            a = 8'(8'h10 + i);
            b = 8'(8'h80 + i);
            cyc(0, 1, 1, 1, a, b, x0, !x0, "cont");
            chk("mh1_gnt0", 32'(d1_gnt0), 32'(i % 2 == 0));
            chk("mh1_gnt1", 32'(d1_gnt1), 32'(i % 2 == 1));
            chk("mh1_mux_sel", 32'(d1_mux_sel), 32'(i % 2 == 1));
            chk("mh1_mux_en", 32'(d1_mux_en), 1);
            chk("mh1_out_valid", 32'(d1_out_valid), 32'(i >= 1));
            if (i >= 1)
                chk("mh1_out_data", 32'(d1_out_data), 32'(((i - 1) % 2 == 0) ? a : b));
        end

        // Early release: req0 drops after 2 contended cycles, hold restarts for GNT1
        cyc(0, 1, 0, 0, 8'h31, 8'h41, 0, 0, "rel_idle");
        cyc(0, 1, 1, 0, 8'h32, 8'h42, 1, 0, "rel_g0");
        cyc(0, 1, 1, 1, 8'h33, 8'h43, 1, 0, "rel_h1");
        cyc(0, 1, 1, 1, 8'h34, 8'h44, 1, 0, "rel_h2");
        cyc(0, 1, 0, 1, 8'h35, 8'h45, 0, 1, "rel_sw");
        cyc(0, 1, 1, 1, 8'h36, 8'h46, 0, 1, "rel_g1a");
        cyc(0, 1, 1, 1, 8'h37, 8'h47, 0, 1, "rel_g1b");
        cyc(0, 1, 1, 1, 8'h38, 8'h48, 0, 1, "rel_g1c");
        cyc(0, 1, 1, 1, 8'h39, 8'h49, 1, 0, "rel_force");

        // Enable drop mid-GNT1, then re-enable with both requesting
        cyc(0, 1, 0, 1, 8'h51, 8'h61, 0, 1, "en_g1");
        cyc(0, 0, 1, 1, 8'h52, 8'h62, 0, 0, "en_off");
        cyc(0, 0, 1, 1, 8'h53, 8'h63, 0, 0, "en_off2");
        chk("en_off_out_valid", 32'(out_valid), 0);
        chk("en_off_out_data",  32'(out_data),  0);
        cyc(0, 1, 1, 1, 8'h54, 8'h64, 1, 0, "en_back");

        // Reset mid-GNT0 (last_gnt=0): after reset req0 must still win
        cyc(1, 1, 1, 1, 8'h71, 8'h72, 0, 0, "mrst");
        chk("mrst_out_valid", 32'(out_valid), 0);
        chk("mrst_out_data",  32'(out_data),  0);
        cyc(0, 1, 1, 1, 8'h73, 8'h74, 1, 0, "mrst_first");

        // Single requester: req1 with A5, then drop
        cyc(0, 1, 0, 0, 8'h81, 8'h91, 0, 0, "one_idle");
        cyc(0, 1, 0, 1, 8'h82, 8'hA5, 0, 1, "one_g1");
        cyc(0, 1, 0, 1, 8'h83, 8'hA5, 0, 1, "one_hold");
        cyc(0, 1, 0, 0, 8'h84, 8'hA5, 0, 0, "one_drop");
        chk("one_out_data", 32'(out_data), 32'(8'hA5));
        cyc(0, 0, 1, 1, 8'h85, 8'h95, 0, 0, "dis_req");
        cyc(0, 0, 0, 0, 8'h86, 8'h96, 0, 0, "dis_idle");
        chk("dis_out_valid", 32'(out_valid), 0);

`ifdef MUX_ARB_STATS_EN
        cyc(1, 1, 0, 0, 8'h00, 8'h00, 0, 0, "st_rst");
        chk("st_rst_cnt0", 32'(gnt_cnt0), 0);
        for (int i = 0; i < 11; i++) cyc(0, 1, 1, 0, 8'(8'hC0 + i), 8'h00, 1, 0, "st_g0");
        chk("st_cnt0", 32'(gnt_cnt0), 10);
        chk("st_cnt1", 32'(gnt_cnt1), 0);
        cyc(0, 1, 0, 0, 8'h00, 8'h00, 0, 0, "st_idle");
`endif

        cyc(0, 1, 0, 0, 8'h00, 8'h00, 0, 0, "drain_a");
        cyc(0, 1, 0, 0, 8'h00, 8'h00, 0, 0, "drain_b");
        chk("sb_drain", 32'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
